// File: rtl/watchdog_kick_scheduler.sv
// Watchdog kick scheduler: collects per-task heartbeats over a window and issues one
// rate-limited kick per window only when every task has checked in. Repeated missed
// windows latch a fault that withholds kicks until supervision is disabled or reset.
module watchdog_kick_scheduler #(
    parameter int unsigned N_TASKS    = 4,
    parameter int unsigned WIN_CYCLES = 100000,
    parameter int unsigned MIN_CYCLES = 1000,
    parameter int unsigned MAX_MISSES = 3,
    parameter int unsigned CNT_W      = 17,
    parameter int unsigned MISS_W     = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [N_TASKS-1:0] task_hb,
    output logic               kick,
    output logic               fault,
    output logic [N_TASKS-1:0] missing_mask,
    output logic [MISS_W-1:0]  miss_count,
    output logic [1:0]         state
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StCollect = 2'd1,
        StKick    = 2'd2,
        StHold    = 2'd3
    } state_e;

    state_e             st;
    logic [CNT_W-1:0]   win_cnt;
    logic [N_TASKS-1:0] seen;
    logic [N_TASKS-1:0] seen_next;
    logic [MISS_W-1:0]  miss_inc;
    logic               all_seen;
    logic               kick_ok;
    logic               win_end;

    assign state = st;

    // Window bookkeeping: heartbeats in the current cycle count toward this window.
    always_comb begin
        seen_next = seen | task_hb;
        all_seen  = &seen_next;
        kick_ok   = (win_cnt >= CNT_W'(MIN_CYCLES - 1));
        win_end   = (win_cnt == CNT_W'(WIN_CYCLES - 1));
        miss_inc  = miss_count + 1'b1;
    end

    // Supervision FSM; all outputs are registered so kick has no input-to-output path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st           <= StIdle;
            kick         <= 1'b0;
            fault        <= 1'b0;
            missing_mask <= '0;
            miss_count   <= '0;
            win_cnt      <= '0;
            seen         <= '0;
        end else begin
            kick <= 1'b0;
            case (st)
                StIdle: begin
                    win_cnt      <= '0;
                    seen         <= '0;
                    miss_count   <= '0;
                    missing_mask <= '0;
                    fault        <= 1'b0;
                    if (enable) begin
                        st <= StCollect;
                    end
                end
                StCollect: begin
                    if (!enable) begin
                        st           <= StIdle;
                        win_cnt      <= '0;
                        seen         <= '0;
                        miss_count   <= '0;
                        missing_mask <= '0;
                        fault        <= 1'b0;
                    end else if (all_seen && kick_ok) begin
                        // Early check-ins wait here until the early-kick guard is met.
                        st   <= StKick;
                        kick <= 1'b1;
                    end else if (win_end) begin
                        missing_mask <= ~seen_next;
                        miss_count   <= miss_inc;
                        seen         <= '0;
                        win_cnt      <= '0;
                        if (miss_inc == MISS_W'(MAX_MISSES)) begin
                            st    <= StHold;
                            fault <= 1'b1;
                        end
                    end else begin
                        seen    <= seen_next;
                        win_cnt <= win_cnt + 1'b1;
                    end
                end
                StKick: begin
                    miss_count   <= '0;
                    missing_mask <= '0;
                    win_cnt      <= '0;
                    if (enable) begin
                        // A heartbeat during the kick cycle belongs to the new window.
                        seen <= task_hb;
                        st   <= StCollect;
                    end else begin
                        seen <= '0;
                        st   <= StIdle;
                    end
                end
                StHold: begin
                    // Frozen diagnostics; only disabling supervision leaves this state.
                    if (!enable) begin
                        st           <= StIdle;
                        fault        <= 1'b0;
                        miss_count   <= '0;
                        missing_mask <= '0;
                    end
                end
                default: st <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/watchdog_kick_scheduler.md
Name: watchdog_kick_scheduler

Overview:
Supervises software/FSM task heartbeats for the plant health monitor and drives the `heartbeat` input of the system `watchdog`. Multiple task heartbeats go in; one kick per window comes out, and only when every task has checked in. Kicks are also rate-limited, so a stuck loop that hammers one heartbeat cannot keep the watchdog fed. After repeated missed windows the block latches a fault and withholds kicks permanently, which lets the watchdog expire and assert `system_reset`.

Parameters:
- N_TASKS, 4, number of supervised task heartbeat inputs.
- WIN_CYCLES, 100000, collection window length in clk cycles (1 ms at 100 MHz); must exceed MIN_CYCLES.
- MIN_CYCLES, 1000, earliest window count at which a kick may issue (early-kick guard); must be ≥1.
- MAX_MISSES, 3, number of consecutive missed windows that causes a fault; must be ≥1.
- CNT_W, 17, window counter width; must satisfy 2^CNT_W > WIN_CYCLES.
- MISS_W, 2, miss counter width; must satisfy 2^MISS_W > MAX_MISSES.

Ports:
- clk, input, 1, system clock. All logic is on the rising edge.
- reset, input, 1, asynchronous, active-low reset.
- enable, input, 1, supervision enable, level sensitive.
- task_hb, input, N_TASKS, per-task heartbeat, one bit per task. Any high cycle counts as a check-in.
- kick, output, 1, one-cycle pulse that connects to `watchdog.heartbeat`.
- fault, output, 1, latched fault after MAX_MISSES consecutive missed windows.
- missing_mask, output, N_TASKS, tasks absent in the most recent missed window.
- miss_count, output, MISS_W, count of consecutive missed windows.
- state, output, 2, debug view of the FSM: IDLE=0, COLLECT=1, KICK=2, HOLD=3.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - kick=0, fault=0, missing_mask=0, miss_count=0.
  - Internal win_cnt=0 and seen=0.
- Outputs are all registered. No combinational path exists from any input to `kick`.
- Definition: seen_next = seen | task_hb.
- IDLE:
  - Counters are held at 0 and kick=0.
  - enable=1 → COLLECT on the next edge, with win_cnt=0 and seen=0.
- COLLECT, evaluated each cycle in this priority order:
  1. enable=0 → IDLE. Clear seen, win_cnt, miss_count, missing_mask and fault.
  2. seen_next is all ones and win_cnt ≥ MIN_CYCLES-1 → KICK.
  3. win_cnt == WIN_CYCLES-1 (window expiry, not all tasks seen):
     - missing_mask ← ~seen_next.
     - miss_count ← miss_count+1.
     - seen ← 0, win_cnt ← 0.
     - If miss_count+1 == MAX_MISSES → HOLD and fault ← 1; otherwise stay in COLLECT.
  4. Otherwise: seen ← seen_next, win_cnt ← win_cnt+1.
- All tasks seen before MIN_CYCLES-1: remain in COLLECT, keep accumulating, and kick when win_cnt reaches MIN_CYCLES-1. This makes the minimum kick spacing MIN_CYCLES+1 cycles.
- A heartbeat arriving in the expiry cycle counts toward that window. Rule 2 is checked before rule 3.
- KICK (exactly one cycle):
  - kick=1.
  - miss_count ← 0, missing_mask ← 0, win_cnt ← 0.
  - seen ← task_hb, so a heartbeat in the KICK cycle is credited to the new window.
  - Next state is COLLECT, or IDLE if enable=0 (seen cleared in that case).
- HOLD:
  - kick is held at 0 and fault=1.
  - missing_mask and miss_count are frozen. task_hb is ignored.
  - Exit only via enable=0 → IDLE (fault cleared) or via reset.
- Counter rules: counters never wrap. win_cnt is bounded by WIN_CYCLES-1, and miss_count is bounded by MAX_MISSES.
- Reset mid-window or mid-kick: kick drops immediately (asynchronously) and state returns to IDLE.

Test Plan:
- The bench uses N_TASKS=4, WIN_CYCLES=100, MIN_CYCLES=10, MAX_MISSES=3.
- Normal kick: enable=1, pulse task_hb=4'b1111 at window cycle 2 → one kick at win_cnt=9. Next kick exactly 11 cycles later if all tasks keep pulsing every cycle. miss_count stays 0.
- Missing task: tasks 0, 1 and 3 pulse every cycle and task 2 never does → no kick; at win_cnt=99 missing_mask=4'b0100 and miss_count=1. Repeat for 3 windows → state=HOLD, fault=1, miss_count=3, and kick stays 0 for a further 1000 cycles.
- Boundary heartbeat: tasks 0, 1 and 2 pulse early and task 3 pulses only at win_cnt=99 → kick on the next cycle, no miss recorded, missing_mask=0.
- Recovery: 2 missed windows (miss_count=2), then a full check-in → kick and miss_count=0. A later single miss gives miss_count=1, not fault.
- Enable/reset mid-operation:
  - Drop enable in HOLD → IDLE with fault=0 next cycle.
  - Assert reset=0 asynchronously during the KICK cycle → kick falls without waiting for a clock edge, all outputs read 0.
  - With the real watchdog connected, a forced HOLD must lead to `system_reset` asserting after the watchdog timeout.
